// File: rtl/pong_game_ctrl_if.sv
// Control/status bundle between the Pong game-flow controller and its
// surroundings; master drives the frame/start/miss inputs, slave is the controller.
interface pong_game_ctrl_if;
  logic       i_VSync;
  logic       i_Game_Start;
  logic       i_Miss_P1;
  logic       i_Miss_P2;
  logic       o_Ball_En;
  logic       o_Ball_Reset;
  logic       o_Paddle_En;
  logic [3:0] o_Score_P1;
  logic [3:0] o_Score_P2;
  logic       o_Game_Over;
  logic       o_Winner;
  logic [2:0] o_State;

  modport master (
    output i_VSync, i_Game_Start, i_Miss_P1, i_Miss_P2,
    input  o_Ball_En, o_Ball_Reset, o_Paddle_En, o_Score_P1, o_Score_P2,
           o_Game_Over, o_Winner, o_State
  );

  modport slave (
    input  i_VSync, i_Game_Start, i_Miss_P1, i_Miss_P2,
    output o_Ball_En, o_Ball_Reset, o_Paddle_En, o_Score_P1, o_Score_P2,
           o_Game_Over, o_Winner, o_State
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game-flow FSM: idle/serve/play/score/game-over, scores, VSync frame timing.
// Optional PONG_AUTO_RESTART_EN: GAME_OVER returns to IDLE after OVER_FRAMES ticks.
module pong_game_ctrl #(
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9,
  parameter int OVER_FRAMES  = 180
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  pong_game_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    RUNNING   = 3'd2,
    POINT_P1  = 3'd3,
    POINT_P2  = 3'd4,
    GAME_OVER = 3'd5
  } state_t;

  // One frame counter is shared by SERVE and GAME_OVER, so size it for the longer wait.
  localparam int CNT_TOP = (SERVE_FRAMES > OVER_FRAMES) ? SERVE_FRAMES : OVER_FRAMES;
  localparam int CW      = $clog2(CNT_TOP + 1);
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);
`ifdef PONG_AUTO_RESTART_EN
  localparam logic [CW-1:0] OVER_LAST  = CW'(OVER_FRAMES - 1);
`endif
  localparam logic [3:0] WIN = 4'(WIN_SCORE);

  state_t        state_q, state_d;
  logic          vsync_q;
  logic          frame_tick;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    s1_q, s1_d, s2_q, s2_d;
  logic          win_q, win_d;
  logic          ball_en_q, ball_en_d;
  logic          ball_rst_q, ball_rst_d;
  logic          paddle_q, paddle_d;
  logic          over_q, over_d;

  assign frame_tick = vsync_q & ~bus.i_VSync;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    win_d   = win_q;
    case (state_q)
      IDLE: if (bus.i_Game_Start) begin
        state_d = SERVE; cnt_d = '0; s1_d = '0; s2_d = '0;
      end
      SERVE: if (frame_tick) begin
        if (cnt_q == SERVE_LAST) begin
          state_d = RUNNING; cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUNNING: begin
        if (bus.i_Miss_P1 && bus.i_Miss_P2) begin
          state_d = SERVE; cnt_d = '0;
        end else if (bus.i_Miss_P1) begin
          state_d = POINT_P2;
        end else if (bus.i_Miss_P2) begin
          state_d = POINT_P1;
        end
      end
      POINT_P1: begin
        s1_d  = s1_q + 4'd1;
        cnt_d = '0;
        if (s1_d == WIN) begin
          state_d = GAME_OVER; win_d = 1'b0;
        end else begin
          state_d = SERVE;
        end
      end
      POINT_P2: begin
        s2_d  = s2_q + 4'd1;
        cnt_d = '0;
        if (s2_d == WIN) begin
          state_d = GAME_OVER; win_d = 1'b1;
        end else begin
          state_d = SERVE;
        end
      end
      GAME_OVER: begin
        if (bus.i_Game_Start) begin
          state_d = SERVE; cnt_d = '0; s1_d = '0; s2_d = '0;
        end
`ifdef PONG_AUTO_RESTART_EN
        else if (frame_tick) begin
          if (cnt_q == OVER_LAST) begin
            state_d = IDLE; cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    ball_en_d  = (state_d == RUNNING);
    ball_rst_d = (state_d == IDLE) || (state_d == SERVE) || (state_d == GAME_OVER);
    paddle_d   = (state_d == SERVE) || (state_d == RUNNING) ||
                 (state_d == POINT_P1) || (state_d == POINT_P2);
    over_d     = (state_d == GAME_OVER);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q    <= IDLE;
      vsync_q    <= 1'b0;
      cnt_q      <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      win_q      <= 1'b0;
      ball_en_q  <= 1'b0;
      ball_rst_q <= 1'b1;
      paddle_q   <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      vsync_q    <= bus.i_VSync;
      cnt_q      <= cnt_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      win_q      <= win_d;
      ball_en_q  <= ball_en_d;
      ball_rst_q <= ball_rst_d;
      paddle_q   <= paddle_d;
      over_q     <= over_d;
    end
  end

  assign bus.o_Ball_En    = ball_en_q;
  assign bus.o_Ball_Reset = ball_rst_q;
  assign bus.o_Paddle_En  = paddle_q;
  assign bus.o_Score_P1   = s1_q;
  assign bus.o_Score_P2   = s2_q;
  assign bus.o_Game_Over  = over_q;
  assign bus.o_Winner     = win_q;
  assign bus.o_State      = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed scenarios plus random stimulus against a
// frame-counting game model.
module tb_pong_game_ctrl;
  localparam int SF = 2, WS = 3, OF = 2;

  logic i_Clk = 1'b0;
  logic i_Reset = 1'b1;
  pong_game_ctrl_if bus();

  pong_game_ctrl #(.SERVE_FRAMES(SF), .WIN_SCORE(WS), .OVER_FRAMES(OF)) dut (
    .i_Clk(i_Clk), .i_Reset(i_Reset), .bus(bus)
  );

  always #5 i_Clk = ~i_Clk;

  int vectors = 0, miscompares = 0;

  // Game model: phase 0 idle, 1 serve, 2 rally, 3/4 point to P1/P2, 5 over.
  int m_state, m_s1, m_s2, m_frames;
  bit m_win, m_vs;

  function automatic void model_step(bit rst, bit vs, bit st, bit m1, bit m2);
    bit tick;
    if (rst) begin
      m_state = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_vs = 0; m_frames = 0;
      return;
    end
    tick = m_vs && !vs;
    m_vs = vs;
    case (m_state)
      0: if (st) begin m_state = 1; m_s1 = 0; m_s2 = 0; m_frames = 0; end
      1: if (tick) begin
        m_frames++;
        if (m_frames == SF) begin m_state = 2; m_frames = 0; end
      end
      2: if (m1 && m2) begin m_state = 1; m_frames = 0; end
         else if (m1) m_state = 4;
         else if (m2) m_state = 3;
      3: begin m_s1++; m_frames = 0;
         if (m_s1 == WS) begin m_state = 5; m_win = 0; end else m_state = 1; end
      4: begin m_s2++; m_frames = 0;
         if (m_s2 == WS) begin m_state = 5; m_win = 1; end else m_state = 1; end
      5: if (st) begin m_state = 1; m_s1 = 0; m_s2 = 0; m_frames = 0; end
`ifdef PONG_AUTO_RESTART_EN
         else if (tick) begin
           m_frames++;
           if (m_frames == OF) begin m_state = 0; m_frames = 0; end
         end
`endif
      default: m_state = 0;
    endcase
  endfunction

  task automatic cyc(input bit vs, input bit st, input bit m1, input bit m2);
    bus.i_VSync = vs; bus.i_Game_Start = st; bus.i_Miss_P1 = m1; bus.i_Miss_P2 = m2;
    model_step(i_Reset, vs, st, m1, m2);
    @(posedge i_Clk); #1;
    bus.i_Game_Start = 1'b0; bus.i_Miss_P1 = 1'b0; bus.i_Miss_P2 = 1'b0;
  endtask

  task automatic frame();
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    i_Reset = 1'b1;
    cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    vectors++; if (bus.o_State !== 3'd0) begin miscompares++; $display("FAIL reset_state got %0d want 0", bus.o_State); end
    vectors++; if (bus.o_Ball_En !== 1'b0) begin miscompares++; $display("FAIL reset_ball_en got %b want 0", bus.o_Ball_En); end
    vectors++; if (bus.o_Ball_Reset !== 1'b1) begin miscompares++; $display("FAIL reset_ball_reset got %b want 1", bus.o_Ball_Reset); end
    vectors++; if (bus.o_Paddle_En !== 1'b0) begin miscompares++; $display("FAIL reset_paddle got %b want 0", bus.o_Paddle_En); end
    vectors++; if (bus.o_Score_P1 !== 4'd0 || bus.o_Score_P2 !== 4'd0) begin miscompares++; $display("FAIL reset_scores got %0d/%0d want 0/0", bus.o_Score_P1, bus.o_Score_P2); end
    vectors++; if (bus.o_Game_Over !== 1'b0 || bus.o_Winner !== 1'b0) begin miscompares++; $display("FAIL reset_over got %b/%b want 0/0", bus.o_Game_Over, bus.o_Winner); end
    i_Reset = 1'b0;
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_start_serve();
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);  // start lands on a frame tick; that tick must not count
    vectors++; if (bus.o_State !== 3'd1) begin miscompares++; $display("FAIL start_state got %0d want 1", bus.o_State); end
    vectors++; if (bus.o_Ball_Reset !== 1'b1 || bus.o_Paddle_En !== 1'b1) begin miscompares++; $display("FAIL serve_outs got %b/%b want 1/1", bus.o_Ball_Reset, bus.o_Paddle_En); end
    vectors++; if (bus.o_Score_P1 !== 4'd0 || bus.o_Score_P2 !== 4'd0) begin miscompares++; $display("FAIL start_scores got %0d/%0d want 0/0", bus.o_Score_P1, bus.o_Score_P2); end
    frame();
    vectors++; if (bus.o_Ball_En !== 1'b0) begin miscompares++; $display("FAIL serve_tick1_ball_en got %b want 0", bus.o_Ball_En); end
    frame();
    vectors++; if (bus.o_Ball_En !== 1'b1 || bus.o_State !== 3'd2) begin miscompares++; $display("FAIL serve_done got en=%b st=%0d want en=1 st=2", bus.o_Ball_En, bus.o_State); end
  endtask

  task automatic test_scoring();
    cyc(0, 0, 1, 0);
    vectors++; if (bus.o_State !== 3'd4 || bus.o_Ball_En !== 1'b0) begin miscompares++; $display("FAIL point_p2 got st=%0d en=%b want st=4 en=0", bus.o_State, bus.o_Ball_En); end
    cyc(0, 0, 0, 0);
    vectors++; if (bus.o_Score_P2 !== 4'd1 || bus.o_Score_P1 !== 4'd0) begin miscompares++; $display("FAIL score_p2 got %0d/%0d want 0/1", bus.o_Score_P1, bus.o_Score_P2); end
    vectors++; if (bus.o_State !== 3'd1 || bus.o_Ball_Reset !== 1'b1) begin miscompares++; $display("FAIL reserve got st=%0d br=%b want st=1 br=1", bus.o_State, bus.o_Ball_Reset); end
    frame(); frame();
    vectors++; if (bus.o_State !== 3'd2) begin miscompares++; $display("FAIL rerun_state got %0d want 2", bus.o_State); end
  endtask

  task automatic test_simultaneous();
    cyc(0, 0, 1, 1);
    vectors++; if (bus.o_State !== 3'd1) begin miscompares++; $display("FAIL double_miss_state got %0d want 1", bus.o_State); end
    vectors++; if (bus.o_Score_P1 !== 4'd0 || bus.o_Score_P2 !== 4'd1) begin miscompares++; $display("FAIL double_miss_scores got %0d/%0d want 0/1", bus.o_Score_P1, bus.o_Score_P2); end
    frame(); frame();
  endtask

  task automatic test_ignored_and_reset();
    cyc(0, 1, 0, 0);
    vectors++; if (bus.o_State !== 3'd2 || bus.o_Score_P2 !== 4'd1) begin miscompares++; $display("FAIL start_in_run got st=%0d p2=%0d want st=2 p2=1", bus.o_State, bus.o_Score_P2); end
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    vectors++; if (bus.o_State !== 3'd1 || bus.o_Score_P1 !== 4'd1 || bus.o_Score_P2 !== 4'd1) begin miscompares++; $display("FAIL ignored_in_serve got st=%0d %0d/%0d want st=1 1/1", bus.o_State, bus.o_Score_P1, bus.o_Score_P2); end
    frame(); frame();
    i_Reset = 1'b1;
    cyc(1, 1, 1, 0);
    vectors++; if (bus.o_State !== 3'd0 || bus.o_Ball_En !== 1'b0 || bus.o_Ball_Reset !== 1'b1 || bus.o_Paddle_En !== 1'b0) begin miscompares++; $display("FAIL midgame_reset got st=%0d en=%b br=%b pd=%b want 0/0/1/0", bus.o_State, bus.o_Ball_En, bus.o_Ball_Reset, bus.o_Paddle_En); end
    vectors++; if (bus.o_Score_P1 !== 4'd0 || bus.o_Score_P2 !== 4'd0 || bus.o_Game_Over !== 1'b0) begin miscompares++; $display("FAIL midgame_reset_scores got %0d/%0d go=%b want 0/0 go=0", bus.o_Score_P1, bus.o_Score_P2, bus.o_Game_Over); end
    i_Reset = 1'b0;
    cyc(0, 0, 0, 0);
  endtask

  task automatic test_win();
    cyc(0, 1, 0, 0);
    frame(); frame();
    for (int i = 0; i < WS; i++) begin
      cyc(0, 0, 0, 1); cyc(0, 0, 0, 0);
      if (i < WS - 1) begin
        vectors++; if (bus.o_State !== 3'd1 || bus.o_Score_P1 !== 4'(i + 1)) begin miscompares++; $display("FAIL win_step got st=%0d p1=%0d want st=1 p1=%0d", bus.o_State, bus.o_Score_P1, i + 1); end
        frame(); frame();
      end
    end
    vectors++; if (bus.o_Score_P1 !== 4'd3 || bus.o_Score_P2 !== 4'd0) begin miscompares++; $display("FAIL win_scores got %0d/%0d want 3/0", bus.o_Score_P1, bus.o_Score_P2); end
    vectors++; if (bus.o_Game_Over !== 1'b1 || bus.o_Winner !== 1'b0 || bus.o_State !== 3'd5) begin miscompares++; $display("FAIL win_over got go=%b w=%b st=%0d want 1/0/5", bus.o_Game_Over, bus.o_Winner, bus.o_State); end
    cyc(0, 0, 1, 0); cyc(0, 0, 0, 1);
    vectors++; if (bus.o_State !== 3'd5 || bus.o_Score_P1 !== 4'd3 || bus.o_Score_P2 !== 4'd0) begin miscompares++; $display("FAIL over_misses got st=%0d %0d/%0d want 5 3/0", bus.o_State, bus.o_Score_P1, bus.o_Score_P2); end
`ifdef PONG_AUTO_RESTART_EN
    frame();
    vectors++; if (bus.o_State !== 3'd5) begin miscompares++; $display("FAIL auto_tick1 got %0d want 5", bus.o_State); end
    frame();
    vectors++; if (bus.o_State !== 3'd0 || bus.o_Score_P1 !== 4'd3 || bus.o_Score_P2 !== 4'd0) begin miscompares++; $display("FAIL auto_restart got st=%0d %0d/%0d want 0 3/0", bus.o_State, bus.o_Score_P1, bus.o_Score_P2); end
`else
    repeat (10) frame();
    vectors++; if (bus.o_State !== 3'd5 || bus.o_Game_Over !== 1'b1 || bus.o_Score_P1 !== 4'd3) begin miscompares++; $display("FAIL over_hold got st=%0d go=%b p1=%0d want 5/1/3", bus.o_State, bus.o_Game_Over, bus.o_Score_P1); end
`endif
    cyc(0, 1, 0, 0);
    vectors++; if (bus.o_State !== 3'd1 || bus.o_Score_P1 !== 4'd0 || bus.o_Score_P2 !== 4'd0 || bus.o_Game_Over !== 1'b0) begin miscompares++; $display("FAIL restart got st=%0d %0d/%0d go=%b want 1 0/0 0", bus.o_State, bus.o_Score_P1, bus.o_Score_P2, bus.o_Game_Over); end
  endtask

  task automatic test_random();
    bit vs, st, m1, m2;
    i_Reset = 1'b1; cyc(0, 0, 0, 0); i_Reset = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      vs = ($urandom_range(0, 2) == 0);
      st = ($urandom_range(0, 29) == 0);
      m1 = ($urandom_range(0, 7) == 0);
      m2 = ($urandom_range(0, 7) == 0);
      i_Reset = ($urandom_range(0, 799) == 0);
      cyc(vs, st, m1, m2);
      vectors++;
      if (bus.o_State !== 3'(m_state) || bus.o_Score_P1 !== 4'(m_s1) || bus.o_Score_P2 !== 4'(m_s2)) begin
        miscompares++;
        $display("FAIL rand_state cyc %0d got st=%0d %0d/%0d want st=%0d %0d/%0d", n, bus.o_State, bus.o_Score_P1, bus.o_Score_P2, m_state, m_s1, m_s2);
      end
      vectors++;
      if (bus.o_Ball_En !== (m_state == 2) || bus.o_Ball_Reset !== (m_state == 0 || m_state == 1 || m_state == 5) ||
          bus.o_Game_Over !== (m_state == 5)) begin
        miscompares++;
        $display("FAIL rand_outs cyc %0d got en=%b br=%b go=%b model st=%0d", n, bus.o_Ball_En, bus.o_Ball_Reset, bus.o_Game_Over, m_state);
      end
      if (m_state == 0 || m_state == 1 || m_state == 2 || m_state == 5) begin
        vectors++;
        if (bus.o_Paddle_En !== (m_state == 1 || m_state == 2)) begin
          miscompares++;
          $display("FAIL rand_paddle cyc %0d got %b model st=%0d", n, bus.o_Paddle_En, m_state);
        end
      end
      if (m_state == 5) begin
        vectors++;
        if (bus.o_Winner !== m_win) begin
          miscompares++;
          $display("FAIL rand_winner cyc %0d got %b want %b", n, bus.o_Winner, m_win);
        end
      end
    end
    i_Reset = 1'b0;
  endtask

  initial begin
    bus.i_VSync = 1'b0; bus.i_Game_Start = 1'b0; bus.i_Miss_P1 = 1'b0; bus.i_Miss_P2 = 1'b0;
    test_reset();
    test_start_serve();
    test_scoring();
    test_simultaneous();
    test_ignored_and_reset();
    test_win();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Game-flow controller for the Pong datapath. Sits between the UART start pulse / ball-miss detection and the ball and paddle logic. Sequences the game through idle, serve, play, scoring and game-over, and holds both players' scores. Frame timing is derived from the VSync pulse, so serve delays are counted in video frames.

## Interface

**Parameters**
- SERVE_FRAMES, 60 — frames the ball is held at centre before each serve; range 1..255.
- WIN_SCORE, 9 — score that ends the game; range 1..15.
- OVER_FRAMES, 180 — frames spent in GAME_OVER before auto-restart; used only with the macro; range 1..255.

**Ports**
- i_Clk, input, 1 — pixel clock (25 MHz).
- i_Reset, input, 1 — synchronous, active-high reset.
- i_VSync, input, 1 — VSync from the sync-pulse generator, synchronous to i_Clk.
- i_Game_Start, input, 1 — single-cycle start pulse (UART data_valid).
- i_Miss_P1, input, 1 — single-cycle pulse: ball passed P1's paddle.
- i_Miss_P2, input, 1 — single-cycle pulse: ball passed P2's paddle.
- o_Ball_En, output, 1 — ball motion enable.
- o_Ball_Reset, output, 1 — hold ball at screen centre.
- o_Paddle_En, output, 1 — paddle motion enable.
- o_Score_P1, output, 4 — P1 score.
- o_Score_P2, output, 4 — P2 score.
- o_Game_Over, output, 1 — high while in GAME_OVER.
- o_Winner, output, 1 — 0 = P1 won, 1 = P2 won; valid while o_Game_Over is high.
- o_State, output, 3 — current state encoding, for debug.

## Operation

**Frame tick.** i_VSync is registered once. The internal frame tick is high for one cycle when the registered value is 1 and i_VSync is 0 (falling edge).

**State encodings.** IDLE = 0, SERVE = 1, RUNNING = 2, POINT_P1 = 3, POINT_P2 = 4, GAME_OVER = 5.

**States and transitions.**
- **IDLE:** ball held at centre, paddles disabled. i_Game_Start → SERVE; scores cleared and frame counter cleared.
- **SERVE:** o_Ball_Reset = 1, o_Paddle_En = 1. The frame counter increments on each tick. The tick on which the count equals SERVE_FRAMES−1 → RUNNING; counter cleared.
- **RUNNING:** o_Ball_En = 1, o_Paddle_En = 1.
  - i_Miss_P1 alone → POINT_P2.
  - i_Miss_P2 alone → POINT_P1.
  - Both in the same cycle → SERVE with no score change.
- **POINT_Px:** lasts exactly one cycle and increments that player's score.
  - If the incremented score equals WIN_SCORE → GAME_OVER, with o_Winner set (P1 → 0, P2 → 1).
  - Otherwise → SERVE; counter cleared.
- **GAME_OVER:** ball held, paddles disabled, scores frozen. i_Game_Start → SERVE; scores cleared.

**Input filtering.**
- i_Game_Start is ignored in SERVE, RUNNING and POINT_*.
- Miss pulses are ignored outside RUNNING.

**Scores.**
- 4-bit unsigned.
- Never exceed WIN_SCORE, so no wrap-around occurs.

**Outputs.** All outputs are registered. o_State reflects the current state register.

## Timing

**Reset values** (state IDLE):
- o_Ball_En = 0, o_Ball_Reset = 1, o_Paddle_En = 0.
- o_Score_P1 = 0, o_Score_P2 = 0.
- o_Game_Over = 0, o_Winner = 0.
- o_State = 0.
- VSync register = 0; frame counter = 0.

**Latencies.**
- i_Game_Start at cycle N → o_State = SERVE and scores cleared at N+1; outputs update at N+1.
- Miss pulse at cycle N:
  - o_Ball_En falls at N+1 (POINT_x).
  - Score increments at N+2.
  - o_Ball_Reset rises at N+2 (SERVE), or o_Game_Over rises at N+2.
- Serve duration: exactly SERVE_FRAMES frame ticks after entering SERVE.
  - A tick in the entry cycle itself does not count.
  - o_Ball_En rises the cycle after the final tick.

**Edge cases.**
- A start pulse coincident with a frame tick is handled normally; the tick is not counted.
- Reset asserted mid-game: on the next edge, all state returns to reset values regardless of pending pulses. Reset has priority over every input.

## Configuration

PONG_AUTO_RESTART_EN

- **Defined:**
  - GAME_OVER also counts frame ticks.
  - After OVER_FRAMES ticks → IDLE; scores are kept visible until the next start.
  - i_Game_Start during GAME_OVER still goes directly to SERVE.
- **Undefined:**
  - GAME_OVER is exited only by i_Game_Start or reset.
  - The frame counter is idle in GAME_OVER.
  - OVER_FRAMES is unused.

## Test plan

Run with SERVE_FRAMES = 2, WIN_SCORE = 3, OVER_FRAMES = 2.

1. **Start and serve.** Reset, then pulse i_Game_Start.
   - SERVE the next cycle.
   - o_Ball_En = 1 exactly one cycle after the 2nd VSync falling edge.
   - Scores 0/0.
2. **Scoring.** In RUNNING, pulse i_Miss_P1.
   - o_Score_P2 = 1 two cycles later.
   - State returns to SERVE, then RUNNING after 2 frames.
3. **Simultaneous miss.** Pulse i_Miss_P1 and i_Miss_P2 in the same cycle.
   - SERVE next cycle; scores unchanged.
4. **Win.** Three i_Miss_P2 pulses (each in RUNNING).
   - o_Score_P1 = 3, o_Game_Over = 1, o_Winner = 0.
   - Subsequent misses and extra frames leave the scores at 3/0.
   - A later i_Game_Start clears the scores and enters SERVE.
5. **Ignored inputs, then reset.** Pulse i_Game_Start during RUNNING and a miss during SERVE; both are ignored. Then assert i_Reset mid-RUNNING.
   - All outputs at reset values the next cycle.
6. **Auto-restart (macro defined).** Reach GAME_OVER.
   - IDLE after 2 frame ticks; scores retained.
   - Without the macro, the state stays GAME_OVER for 10 frames.
